alu_muldiv: RTL and testbench

//  Parametrised next-generation ALU for the multicycle datapath. Single-cycle ops
//  (add/sub/logic/shift/slt/branch compare) are combinational, then registered.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/muldiv_seq.sv | 142 ++++++++++++++
 rtl/alu_muldiv.sv | 115 +++++++++++
 tb/tb_alu_muldiv.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - aluctrl operation codes and mult/div FSM state encoding
// Ports: none (package).
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_MULT = 4'b0111;
    localparam logic [3:0] ALU_DIV  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_XOR  = 4'b1011;
    localparam logic [3:0] ALU_BEQ  = 4'b1101;
    localparam logic [3:0] ALU_BNE  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative shift-add multiplier / restoring divider with hi/lo
// Ports: clk, reset (sync, active-high); srca/srcb operands; msigned;
//   start_mul/start_div launch requests; busy, done pulse, hi/lo results.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             msigned,
    input  logic             start_mul,
    input  logic             start_div,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e          r_state;
    md_state_e          w_next;
    logic [CW-1:0]      r_cnt;
    // Mult: {partial product, multiplier}. Div: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_op_div;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    // A start coinciding with the done cycle is dropped as well as one while busy.
    assign w_accept = (r_state == S_IDLE) && !r_done && (start_mul || start_div);
    assign w_sign_a = msigned & srca[WIDTH-1];
    assign w_sign_b = msigned & srcb[WIDTH-1];
    assign w_abs_a  = w_sign_a ? -srca : srca;
    assign w_abs_b  = w_sign_b ? -srcb : srcb;

    assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_next = {w_madd, r_acc[WIDTH-1:1]};

    // Borrow in w_trial[WIDTH] means the trial subtraction failed: restore by plain shift.
    assign w_trial    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opb};
    assign w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_quo = r_acc[WIDTH-1:0];
    assign w_rem = r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (w_accept) w_next = start_mul ? S_MUL : S_DIV;
            S_MUL, S_DIV: if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIN;
            S_FIN:        w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_op_div <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= '0;
                        r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
                        r_opb    <= w_abs_b;
                        r_neg_q  <= w_sign_a ^ w_sign_b;
                        r_neg_r  <= w_sign_a;
                        r_dz     <= (srcb == '0);
                        r_op_div <= start_div;
                        r_busy   <= 1'b1;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIN: begin
                    if (r_op_div) begin
                        r_lo <= r_dz ? '1 : (r_neg_q ? -w_quo : w_quo);
                        r_hi <= r_neg_r ? -w_rem : w_rem;
                    end else begin
                        {r_hi, r_lo} <= r_neg_q ? -r_acc : r_acc;
                    end
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - combinational ALU with flags, registered result and mult/div engine
// Ports: clk, reset (sync, active-high); srca/srcb operands; aluctrl op select;
//   shamt shift amount; msigned/start mult/div controls; aluout (comb) and
//   aluresult (registered); cout/ov/zero/sign flags; busy/done/hi/lo results.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [3:0]       aluctrl,
    input  logic [SHW-1:0]   shamt,
    input  logic             msigned,
    input  logic             start,
    output logic [WIDTH-1:0] aluout,
    output logic [WIDTH-1:0] aluresult,
    output logic             cout,
    output logic             ov,
    output logic             zero,
    output logic             sign,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_ovf;
    logic             w_lt_s;
    logic             w_lt_u;
    logic             w_valid;
    logic             w_start_mul;
    logic             w_start_div;
    logic [WIDTH-1:0] r_aluresult;

    // SUB and both branch compares share the A + ~B + 1 adder path.
    assign w_is_sub = (aluctrl == ALU_SUB) || (aluctrl == ALU_BEQ) || (aluctrl == ALU_BNE);
    assign w_b_eff  = w_is_sub ? ~srcb : srcb;
    assign {w_carry, w_sum} = {1'b0, srca} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
    // Signed overflow: equal-sign addends producing a sum of the other sign.
    assign w_ovf  = (srca[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != srca[WIDTH-1]);
    assign w_lt_s = $signed(srca) < $signed(srcb);
    assign w_lt_u = srca < srcb;

    always_comb begin
        aluout  = '0;
        cout    = 1'b0;
        ov      = 1'b0;
        zero    = 1'b0;
        w_valid = 1'b1;
        case (aluctrl)
            ALU_ADD, ALU_SUB: begin
                aluout = w_sum;
                cout   = w_carry;
                ov     = w_ovf;
            end
            ALU_AND:           aluout = srca & srcb;
            ALU_OR:            aluout = srca | srcb;
            ALU_NOR:           aluout = ~(srca | srcb);
            ALU_XOR:           aluout = srca ^ srcb;
            ALU_SLL:           aluout = srcb << shamt;
            ALU_SRL:           aluout = srcb >> shamt;
            ALU_SLT:           aluout = {{(WIDTH-1){1'b0}}, w_lt_s};
            ALU_SLTU:          aluout = {{(WIDTH-1){1'b0}}, w_lt_u};
            ALU_BEQ, ALU_BNE:  aluout = w_sum;
            ALU_MULT, ALU_DIV: aluout = '0;
            default:           w_valid = 1'b0;
        endcase
        if (aluctrl == ALU_BEQ) begin
            zero = (srca == srcb);
        end else if (aluctrl == ALU_BNE) begin
            zero = (srca != srcb);
        end else begin
            zero = w_valid && (aluout == '0);
        end
    end

    assign sign = aluout[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_aluresult <= '0;
        end else begin
            r_aluresult <= aluout;
        end
    end

    assign aluresult = r_aluresult;

    assign w_start_mul = start && (aluctrl == ALU_MULT);
    assign w_start_div = start && (aluctrl == ALU_DIV);

    muldiv_seq #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .srca     (srca),
        .srcb     (srcb),
        .msigned  (msigned),
        .start_mul(w_start_mul),
        .start_div(w_start_div),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench for alu_muldiv at WIDTH=32 and WIDTH=16
module tb_alu_muldiv;
    import alu_pkg::*;

    typedef struct packed {
        logic [63:0] out;
        logic        cout;
        logic        ov;
        logic        zero;
        logic        sign;
    } alu_exp_t;

    typedef struct packed {
        logic [63:0] hi;
        logic [63:0] lo;
    } md_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] a_in, b_in;
    logic [3:0]  ctrl;
    logic [4:0]  sh_in;
    logic        sgn, start;

    logic [31:0] d32_out, d32_res, d32_hi, d32_lo;
    logic        d32_cout, d32_ov, d32_zero, d32_sign, d32_busy, d32_done;
    logic [15:0] d16_out, d16_res, d16_hi, d16_lo;
    logic        d16_cout, d16_ov, d16_zero, d16_sign, d16_busy, d16_done;

    int          cw;
    logic [63:0] mask;
    int          n_checks, n_pass;

    logic [63:0] o_out, o_res, o_hi, o_lo;
    logic        o_cout, o_ov, o_zero, o_sign, o_busy, o_done;

    alu_exp_t    aq[$];
    md_exp_t     mq[$];
    logic [3:0]  vc_q[$];
    logic [63:0] va_q[$], vb_q[$];
    int          vs_q[$];

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(32), .SHW(5)) dut32 (
        .clk(clk), .reset(reset), .srca(a_in[31:0]), .srcb(b_in[31:0]), .aluctrl(ctrl),
        .shamt(sh_in[4:0]), .msigned(sgn), .start(start), .aluout(d32_out),
        .aluresult(d32_res), .cout(d32_cout), .ov(d32_ov), .zero(d32_zero), .sign(d32_sign),
        .busy(d32_busy), .done(d32_done), .hi(d32_hi), .lo(d32_lo)
    );

    alu_muldiv #(.WIDTH(16), .SHW(4)) dut16 (
        .clk(clk), .reset(reset), .srca(a_in[15:0]), .srcb(b_in[15:0]), .aluctrl(ctrl),
        .shamt(sh_in[3:0]), .msigned(sgn), .start(start), .aluout(d16_out),
        .aluresult(d16_res), .cout(d16_cout), .ov(d16_ov), .zero(d16_zero), .sign(d16_sign),
        .busy(d16_busy), .done(d16_done), .hi(d16_hi), .lo(d16_lo)
    );

    always_comb begin
        if (cw == 16) begin
            o_out = {48'd0, d16_out}; o_res = {48'd0, d16_res};
            o_hi = {48'd0, d16_hi}; o_lo = {48'd0, d16_lo};
            o_cout = d16_cout; o_ov = d16_ov; o_zero = d16_zero; o_sign = d16_sign;
            o_busy = d16_busy; o_done = d16_done;
        end else begin
            o_out = {32'd0, d32_out}; o_res = {32'd0, d32_res};
            o_hi = {32'd0, d32_hi}; o_lo = {32'd0, d32_lo};
            o_cout = d32_cout; o_ov = d32_ov; o_zero = d32_zero; o_sign = d32_sign;
            o_busy = d32_busy; o_done = d32_done;
        end
    end

    function automatic longint sx(input logic [63:0] v, input int w);
        if (v[w-1]) return longint'(v) - (longint'(1) << w);
        return longint'(v);
    endfunction

    function automatic alu_exp_t alu_model(input logic [3:0] c, input logic [63:0] a,
                                           input logic [63:0] b, input int sh, input int w);
        alu_exp_t    e;
        logic [63:0] m, t;
        longint      sa, sb;
        bit          valid;
        m = (64'd1 << w) - 64'd1;
        e = '0;
        t = '0;
        valid = 1'b1;
        sa = sx(a, w);
        sb = sx(b, w);
        case (c)
            ALU_ADD: begin
                t = a + b; e.out = t & m; e.cout = t[w]; e.ov = (sa + sb) != sx(t & m, w);
            end
            ALU_SUB: begin
                t = a + (~b & m) + 64'd1; e.out = t & m; e.cout = t[w];
                e.ov = (sa - sb) != sx(t & m, w);
            end
            ALU_AND:  e.out = a & b;
            ALU_OR:   e.out = a | b;
            ALU_NOR:  e.out = ~(a | b) & m;
            ALU_XOR:  e.out = a ^ b;
            ALU_SLL:  e.out = (b << sh) & m;
            ALU_SRL:  e.out = b >> sh;
            ALU_SLT:  e.out = 64'(sa < sb);
            ALU_SLTU: e.out = 64'(a < b);
            ALU_BEQ, ALU_BNE: e.out = (a - b) & m;
            default:  valid = 1'b0;
        endcase
        if (c == ALU_BEQ) e.zero = (a == b);
        else if (c == ALU_BNE) e.zero = (a != b);
        else e.zero = valid && (e.out == 64'd0);
        e.sign = e.out[w-1];
        return e;
    endfunction

    function automatic md_exp_t md_model(input logic [63:0] a, input logic [63:0] b,
                                         input bit is_div, input bit s, input int w);
        md_exp_t     e;
        logic [63:0] m, p;
        longint      sa, sb;
        m = (64'd1 << w) - 64'd1;
        sa = sx(a, w);
        sb = sx(b, w);
        if (!is_div) begin
            p = s ? 64'(sa * sb) : (a * b);
            e.hi = (p >> w) & m;
            e.lo = p & m;
        end else if (b == 64'd0) begin
            e.lo = m;
            e.hi = a;
        end else if (s) begin
            e.lo = 64'(sa / sb) & m;
            e.hi = 64'(sa % sb) & m;
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    task automatic add_vec(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                           input int s);
        vc_q.push_back(c);
        va_q.push_back(a & mask);
        vb_q.push_back(b & mask);
        vs_q.push_back(s);
    endtask

    task automatic launch(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic s);
        @(posedge clk);
        @(negedge clk);
        ctrl = op; a_in = a & mask; b_in = b & mask; sgn = s; start = 1'b1;
        mq.push_back(md_model(a & mask, b & mask, op == ALU_DIV, s, cw));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns with time at #1 after the edge where done was first seen high.
    task automatic wait_done(output int ncyc, output int nbusy, output bit got);
        ncyc = 0; nbusy = 0; got = 1'b0;
        while (!got && ncyc < cw + 10) begin
            if (o_done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (o_busy === 1'b1) nbusy++;
                @(posedge clk); #1;
                ncyc++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; ctrl = ALU_OR; a_in = mask; b_in = 64'd1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (o_res !== 64'd0) $display("FAIL w%0d reset_aluresult got=%h exp=0", cw, o_res);
        else n_pass++;
        n_checks++;
        if ({o_hi, o_lo} !== 128'd0) $display("FAIL w%0d reset_hilo got=%h/%h exp=0", cw, o_hi, o_lo);
        else n_pass++;
        n_checks++;
        if ({o_busy, o_done} !== 2'b00) $display("FAIL w%0d reset_busy_done got=%b%b exp=00", cw, o_busy, o_done);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu();
        logic [63:0] msb;
        alu_exp_t    e;
        logic [3:0]  vc [0:11];
        vc = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR,
               ALU_SLL, ALU_SRL, ALU_SLT, ALU_SLTU, ALU_BEQ, ALU_BNE};
        msb = 64'd1 << (cw - 1);
        vc_q.delete(); va_q.delete(); vb_q.delete(); vs_q.delete();
        add_vec(ALU_ADD, mask, 64'd1, 0);
        add_vec(ALU_ADD, mask >> 1, 64'd1, 0);
        add_vec(ALU_SLT, mask, 64'd1, 0);
        add_vec(ALU_SLTU, mask, 64'd1, 0);
        add_vec(ALU_SLL, 64'd0, 64'd1, cw - 1);
        add_vec(ALU_BNE, 64'd5, 64'd5, 0);
        add_vec(ALU_BEQ, 64'd5, 64'd5, 0);
        add_vec(ALU_BEQ, 64'd5, 64'd9, 0);
        add_vec(ALU_SUB, 64'd0, 64'd1, 0);
        add_vec(ALU_SUB, 64'd5, 64'd3, 0);
        add_vec(ALU_SUB, msb, 64'd1, 0);
        add_vec(ALU_SRL, 64'd0, msb | 64'd1, cw - 2);
        add_vec(ALU_NOR, mask, 64'd0, 0);
        add_vec(4'b1100, mask, 64'd3, 0);
        add_vec(4'b1110, 64'd7, 64'd3, 0);
        for (int i = 0; i < 24; i++)
            add_vec(vc[$urandom_range(0, 11)], {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, cw - 1)));
        foreach (vc_q[i]) begin
            @(negedge clk);
            ctrl = vc_q[i]; a_in = va_q[i]; b_in = vb_q[i]; sh_in = 5'(vs_q[i]); start = 1'b0;
            aq.push_back(alu_model(vc_q[i], va_q[i], vb_q[i], vs_q[i], cw));
            #1;
            e = aq.pop_front();
            n_checks++;
            if (o_out !== e.out)
                $display("FAIL w%0d alu_out[%0d] op=%b got=%h exp=%h", cw, i, vc_q[i], o_out, e.out);
            else n_pass++;
            n_checks++;
            if ({o_cout, o_ov, o_zero, o_sign} !== {e.cout, e.ov, e.zero, e.sign})
                $display("FAIL w%0d alu_flags[%0d] op=%b got=%b exp=%b", cw, i, vc_q[i],
                         {o_cout, o_ov, o_zero, o_sign}, {e.cout, e.ov, e.zero, e.sign});
            else n_pass++;
            @(posedge clk); #1;
            n_checks++;
            if (o_res !== e.out)
                $display("FAIL w%0d aluresult[%0d] got=%h exp=%h", cw, i, o_res, e.out);
            else n_pass++;
        end
    endtask

    task automatic test_muldiv();
        logic [3:0]  op_q[$];
        logic [63:0] a_q[$], b_q[$];
        bit          s_q[$];
        logic [63:0] msb;
        md_exp_t     e;
        int          ncyc, nbusy;
        bit          got;
        msb = 64'd1 << (cw - 1);
        op_q = '{ALU_MULT, ALU_MULT, ALU_MULT, ALU_MULT, ALU_MULT,
                 ALU_DIV, ALU_DIV, ALU_DIV, ALU_DIV, ALU_DIV, ALU_DIV, ALU_DIV};
        a_q  = '{mask, mask - 64'd2, msb, msb, 64'd12345,
                 mask - 64'd6, 64'd9, msb, mask - 64'd8, 64'd100, mask - 64'd99, 64'd7};
        b_q  = '{mask, 64'd7, msb, mask, 64'd678,
                 64'd2, 64'd0, mask, 64'd0, 64'd7, 64'd7, mask - 64'd1};
        s_q  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            op_q.push_back(i[0] ? ALU_DIV : ALU_MULT);
            a_q.push_back({$urandom, $urandom});
            b_q.push_back({$urandom, $urandom} | 64'd1);
            s_q.push_back(i[1]);
        end
        foreach (op_q[i]) begin
            launch(op_q[i], a_q[i], b_q[i], s_q[i]);
            wait_done(ncyc, nbusy, got);
            e = mq.pop_front();
            n_checks++;
            if (!got || ncyc != cw + 1 || nbusy != cw + 1)
                $display("FAIL w%0d md_latency[%0d] got done=%0b cycles=%0d busy=%0d exp cycles=%0d busy=%0d",
                         cw, i, got, ncyc, nbusy, cw + 1, cw + 1);
            else n_pass++;
            n_checks++;
            if ({o_hi, o_lo} !== {e.hi, e.lo})
                $display("FAIL w%0d md_hilo[%0d] op=%b got=%h/%h exp=%h/%h",
                         cw, i, op_q[i], o_hi, o_lo, e.hi, e.lo);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        md_exp_t     e;
        alu_exp_t    ea;
        int          ncyc, nbusy, ndone;
        bit          got;
        logic [63:0] x, y;
        launch(ALU_DIV, 64'd100, 64'd7, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        ctrl = ALU_MULT; a_in = 64'd5; b_in = 64'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        x = {$urandom, $urandom} & mask; y = {$urandom, $urandom} & mask;
        ctrl = ALU_ADD; a_in = x; b_in = y;
        aq.push_back(alu_model(ALU_ADD, x, y, 0, cw));
        #1;
        ea = aq.pop_front();
        n_checks++;
        if (o_out !== ea.out || o_busy !== 1'b1)
            $display("FAIL w%0d add_while_busy got=%h busy=%b exp=%h busy=1", cw, o_out, o_busy, ea.out);
        else n_pass++;
        wait_done(ncyc, nbusy, got);
        e = mq.pop_front();
        n_checks++;
        if (!got || {o_hi, o_lo} !== {e.hi, e.lo})
            $display("FAIL w%0d b2b_first_op got done=%0b %h/%h exp %h/%h", cw, got, o_hi, o_lo, e.hi, e.lo);
        else n_pass++;
        ctrl = ALU_MULT; a_in = 64'd3; b_in = 64'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL w%0d start_on_done got busy=%b exp=0", cw, o_busy);
        else n_pass++;
        ndone = 0;
        for (int i = 0; i < cw + 6; i++) begin
            if (o_done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (ndone != 0 || {o_hi, o_lo} !== {e.hi, e.lo})
            $display("FAIL w%0d ignored_starts got dones=%0d %h/%h exp 0 %h/%h",
                     cw, ndone, o_hi, o_lo, e.hi, e.lo);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        md_exp_t e;
        int      ncyc, nbusy, ndone;
        bit      got;
        launch(ALU_MULT, mask, mask, 1'b0);
        void'(mq.pop_back());
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({o_busy, o_done} !== 2'b00 || {o_hi, o_lo} !== 128'd0)
            $display("FAIL w%0d reset_mid got busy=%b done=%b %h/%h exp 0 0 0/0",
                     cw, o_busy, o_done, o_hi, o_lo);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < cw + 6; i++) begin
            if (o_done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (ndone != 0) $display("FAIL w%0d no_done_after_abort got=%0d exp=0", cw, ndone);
        else n_pass++;
        launch(ALU_MULT, mask - 64'd2, 64'd7, 1'b1);
        wait_done(ncyc, nbusy, got);
        e = mq.pop_front();
        n_checks++;
        if (!got || {o_hi, o_lo} !== {e.hi, e.lo})
            $display("FAIL w%0d mult_after_reset got done=%0b %h/%h exp %h/%h",
                     cw, got, o_hi, o_lo, e.hi, e.lo);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        reset = 1'b1; start = 1'b0; ctrl = ALU_ADD; a_in = '0; b_in = '0; sh_in = '0; sgn = 1'b0;
        cw = 32; mask = 64'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            cw = (k == 0) ? 32 : 16;
            mask = (64'd1 << cw) - 64'd1;
            test_reset();
            test_alu();
            test_muldiv();
            test_back_to_back();
            test_reset_mid();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
